// File: rtl/router_pkg.sv
// router_pkg: shared FSM states, address constants and header helpers for the router packet source.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction
  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction
  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:ADDR_W];
  endfunction
endpackage

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: emits header/payload/parity packets toward the router, stalling on busy.
// Optional ROUTER_TX_PARITY_ERR_EN adds req_bad_parity to corrupt the parity byte on demand.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_seed,
`ifdef ROUTER_TX_PARITY_ERR_EN
  input  logic              req_bad_parity,
`endif
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              err,
  output logic [15:0]       pkt_count
);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0] len_q, len_n, cnt, cnt_n;
  logic [DATA_W-1:0] pay, pay_n, par, par_n, data_n;
  logic [3:0] gap, gap_n;
  logic [15:0] count_n;
  logic bad_q, bad_n, bad_in, done_n, err_n, pv_n, ready_n;
`ifdef ROUTER_TX_PARITY_ERR_EN
  assign bad_in = req_bad_parity;
`else
  assign bad_in = 1'b0;
`endif
  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    len_n   = len_q;
    cnt_n   = cnt;
    pay_n   = pay;
    par_n   = par;
    gap_n   = gap;
    bad_n   = bad_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    count_n = pkt_count;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        if (req_addr == ILLEGAL_ADDR || req_len == '0) begin
          done_n = 1'b1;
          err_n  = 1'b1;
        end else begin
          state_n = HEADER;
          addr_n  = req_addr;
          len_n   = req_len;
          pay_n   = req_seed;
          par_n   = {req_len, req_addr};
          bad_n   = bad_in;
        end
      end
      HEADER: if (!busy) begin
        state_n = PAYLOAD;
        cnt_n   = len_q;
      end
      PAYLOAD: if (!busy) begin
        par_n   = par ^ pay;
        pay_n   = pay + 1'b1;
        cnt_n   = cnt - 1'b1;
        state_n = (cnt == LEN_ONE) ? PARITY : PAYLOAD;
      end
      PARITY: if (!busy) begin
        done_n  = 1'b1;
        count_n = pkt_count + 16'd1;
        gap_n   = '0;
        state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        gap_n   = gap + 4'd1;
        state_n = (gap == GAP_LAST) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from next-state values, so they hold while busy stalls the FSM.
  always_comb begin
    pv_n    = state_n == HEADER || state_n == PAYLOAD;
    ready_n = state_n == IDLE && !done_n;
    data_n  = state_n == HEADER  ? {len_n, addr_n} :
              state_n == PAYLOAD ? pay_n :
              state_n == PARITY  ? par_n ^ {{(DATA_W-1){1'b0}}, bad_n} : '0;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      pay       <= '0;
      par       <= '0;
      gap       <= '0;
      bad_q     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pkt_count <= '0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      len_q     <= len_n;
      cnt       <= cnt_n;
      pay       <= pay_n;
      par       <= par_n;
      gap       <= gap_n;
      bad_q     <= bad_n;
      done      <= done_n;
      err       <= err_n;
      pkt_count <= count_n;
      pkt_valid <= pv_n;
      data_out  <= data_n;
      req_ready <= ready_n;
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx (define ROUTER_TX_PARITY_ERR_EN for the parity-corruption case).
module tb_router_pkt_tx;
  logic clock, resetn, req_valid, req_ready, busy, pkt_valid, done, err;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic [7:0] req_seed, data_out;
  logic [15:0] pkt_count;
`ifdef ROUTER_TX_PARITY_ERR_EN
  logic req_bad_parity;
`endif
  int total, bad, unstable, cycles;
  logic [7:0] got_d[$];
  logic got_pv[$];

  router_pkt_tx dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_seed(req_seed),
`ifdef ROUTER_TX_PARITY_ERR_EN
    .req_bad_parity(req_bad_parity),
`endif
    .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out), .done(done), .err(err),
    .pkt_count(pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] exp_byte(logic [1:0] a, logic [5:0] l, logic [7:0] s, logic bp, int k);
    logic [7:0] p;
    p = {l, a};
    if (k == 0) return p;
    if (k <= int'(l)) return s + 8'(k - 1);
    for (int i = 0; i < int'(l); i++) p = p ^ (s + 8'(i));
    return p ^ {7'b0, bp};
  endfunction

  function automatic int bad_bytes(logic [1:0] a, logic [5:0] l, logic [7:0] s, logic bp);
    int n;
    n = 0;
    if (got_d.size() != int'(l) + 2) return 1000;
    for (int k = 0; k < int'(l) + 2; k++)
      if (got_d[k] !== exp_byte(a, l, s, bp, k) || got_pv[k] !== (k <= int'(l))) n++;
    return n;
  endfunction

  task automatic drive_pkt(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input logic bp,
                           input int hstall, input int sidx, input int sn);
    int n, k, stall;
    logic pb, ppv;
    logic [7:0] pd;
    got_d.delete();
    got_pv.delete();
    unstable = 0;
    cycles = 0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_len = l; req_seed = s;
`ifdef ROUTER_TX_PARITY_ERR_EN
    req_bad_parity = bp;
`endif
    @(negedge clock);
    req_valid = 1'b0;
    k = 0; stall = hstall; pb = 1'b0; pd = '0; ppv = 1'b0;
    while (k < int'(l) + 2 && cycles < 1000) begin
      if (pb && (data_out !== pd || pkt_valid !== ppv)) unstable++;
      busy = stall > 0;
      if (stall > 0) stall--;
      pd = data_out; ppv = pkt_valid; pb = busy;
      if (!busy) begin
        got_d.push_back(data_out);
        got_pv.push_back(pkt_valid);
        k++;
        stall = (k == sidx) ? sn : 0;
      end
      @(negedge clock);
      cycles++;
    end
    busy = 1'b0;
    if (k < int'(l) + 2) begin
      total++; bad++;
      $display("FAIL pkt_timeout: bytes=%0d required %0d", k, int'(l) + 2);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({pkt_valid, data_out, req_ready, done, err, pkt_count} !== 28'd0) begin
      bad++;
      $display("FAIL reset_state: pv=%b d=%h rdy=%b done=%b err=%b cnt=%h required all 0",
               pkt_valid, data_out, req_ready, done, err, pkt_count);
    end
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready); end
  endtask

  task automatic test_basic;
    int nb;
    drive_pkt(2'd1, 6'd3, 8'h10, 1'b0, 0, 0, 0);
    nb = bad_bytes(2'd1, 6'd3, 8'h10, 1'b0);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL basic_bytes: bad_bytes=%0d required 0", nb); end
    total++;
    if (got_d.size() == 5 && got_d[4] !== 8'h1E) begin bad++; $display("FAIL basic_parity: got %h required 1e", got_d[4]); end
    total++;
    if (cycles !== 5) begin bad++; $display("FAIL basic_cycles: got %0d required 5", cycles); end
    total++;
    if ({done, err, req_ready, pkt_valid, data_out} !== {4'b1000, 8'h00}) begin
      bad++;
      $display("FAIL basic_done: done=%b err=%b rdy=%b pv=%b d=%h required 1 0 0 0 00", done, err, req_ready, pkt_valid, data_out);
    end
    total++;
    if (pkt_count !== 16'd1) begin bad++; $display("FAIL basic_count: got %0d required 1", pkt_count); end
    @(negedge clock);
    total++;
    if ({done, req_ready} !== 2'b00) begin bad++; $display("FAIL basic_gap: done=%b rdy=%b required 0 0", done, req_ready); end
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_idle: rdy=%b required 1", req_ready); end
  endtask

  task automatic test_stall;
    int nb;
    drive_pkt(2'd1, 6'd3, 8'h10, 1'b0, 4, 2, 2);
    nb = bad_bytes(2'd1, 6'd3, 8'h10, 1'b0);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL stall_bytes: bad_bytes=%0d required 0", nb); end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL stall_hold: changes=%0d required 0", unstable); end
    total++;
    if (cycles !== 11) begin bad++; $display("FAIL stall_cycles: got %0d required 11", cycles); end
    total++;
    if ({done, err, pkt_count} !== {2'b10, 16'd2}) begin
      bad++;
      $display("FAIL stall_done: done=%b err=%b cnt=%0d required 1 0 2", done, err, pkt_count);
    end
  endtask

  task automatic test_reject;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5; req_seed = 8'h33;
    @(negedge clock);
    req_valid = 1'b0;
    total++;
    if ({done, err, pkt_valid, pkt_count} !== {3'b110, 16'd2}) begin
      bad++;
      $display("FAIL reject_done: done=%b err=%b pv=%b cnt=%0d required 1 1 0 2", done, err, pkt_valid, pkt_count);
    end
    @(negedge clock);
    total++;
    if ({req_ready, done, pkt_valid} !== 3'b100) begin
      bad++;
      $display("FAIL reject_idle: rdy=%b done=%b pv=%b required 1 0 0", req_ready, done, pkt_valid);
    end
    req_valid = 1'b1; req_addr = 2'd0; req_len = 6'd0;
    @(negedge clock);
    req_valid = 1'b0;
    total++;
    if ({done, err, pkt_valid} !== 3'b110) begin
      bad++;
      $display("FAIL reject_len0: done=%b err=%b pv=%b required 1 1 0", done, err, pkt_valid);
    end
  endtask

  task automatic test_wrap;
    int nb;
    drive_pkt(2'd2, 6'd63, 8'hF0, 1'b0, 0, 0, 0);
    nb = bad_bytes(2'd2, 6'd63, 8'hF0, 1'b0);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL wrap_bytes: bad_bytes=%0d required 0", nb); end
    total++;
    if (got_d.size() == 65 && {got_d[16], got_d[17]} !== 16'hFF00) begin
      bad++;
      $display("FAIL wrap_edge: got %h %h required ff 00", got_d[16], got_d[17]);
    end
    total++;
    if (pkt_count !== 16'd3) begin bad++; $display("FAIL wrap_count: got %0d required 3", pkt_count); end
  endtask

`ifdef ROUTER_TX_PARITY_ERR_EN
  task automatic test_parity_err;
    drive_pkt(2'd0, 6'd1, 8'h00, 1'b1, 0, 0, 0);
    total++;
    if (got_d.size() != 3 || {got_d[0], got_d[1], got_d[2]} !== 24'h040005) begin
      bad++;
      $display("FAIL perr_bytes: size=%0d required bytes 04 00 05", got_d.size());
    end
    total++;
    if (pkt_count !== 16'd4) begin bad++; $display("FAIL perr_count: got %0d required 4", pkt_count); end
    req_bad_parity = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    int nb, n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    req_valid = 1'b1; req_addr = 2'd2; req_len = 6'd6; req_seed = 8'h40;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({pkt_valid, data_out} !== 9'h141) begin bad++; $display("FAIL mid_payload: pv=%b d=%h required 1 41", pkt_valid, data_out); end
    resetn = 1'b0;
    @(negedge clock);
    total++;
    if ({pkt_valid, data_out, req_ready, done, pkt_count} !== 27'd0) begin
      bad++;
      $display("FAIL mid_reset: pv=%b d=%h rdy=%b done=%b cnt=%0d required all 0", pkt_valid, data_out, req_ready, done, pkt_count);
    end
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if ({req_ready, pkt_valid} !== 2'b10) begin bad++; $display("FAIL mid_idle: rdy=%b pv=%b required 1 0", req_ready, pkt_valid); end
    drive_pkt(2'd0, 6'd2, 8'h7F, 1'b0, 1, 1, 1);
    nb = bad_bytes(2'd0, 6'd2, 8'h7F, 1'b0);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL mid_newpkt: bad_bytes=%0d required 0", nb); end
    total++;
    if ({done, err, pkt_count} !== {2'b10, 16'd1}) begin
      bad++;
      $display("FAIL mid_count: done=%b err=%b cnt=%0d required 1 0 1", done, err, pkt_count);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_seed = '0; busy = 1'b0;
`ifdef ROUTER_TX_PARITY_ERR_EN
    req_bad_parity = 1'b0;
`endif
    @(negedge clock);
    test_reset;
    test_basic;
    test_stall;
    test_reject;
    test_wrap;
`ifdef ROUTER_TX_PARITY_ERR_EN
    test_parity_err;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
